// File: rtl/ram_readback_checker.sv
//==============================================================================
// ram_readback_checker: port-B readback sweep, compares each word with SEED+addr.
// Optional first-mismatch capture enabled by macro RBC_FIRST_ERR_CAPTURE_EN.
// Revision: 1.0
//==============================================================================
`default_nettype none

module ram_readback_checker #(
    parameter int RAM_SIZE   = 2048,
    parameter int ADDR_W     = 20,
    parameter int DATA_W     = 16,
    parameter int RD_LATENCY = 1,
    parameter int SEED       = 1,
    parameter int ERR_W      = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [DATA_W-1:0] first_err_data,
    output logic              ram_enb,
    output logic [ADDR_W-1:0] ram_addrb,
    input  logic [DATA_W-1:0] ram_doutb
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] C_LAST_ADDR = ADDR_W'(RAM_SIZE - 1);
    localparam logic [DATA_W-1:0] C_SEED      = DATA_W'(SEED);

    state_t                           r_state;
    state_t                           w_state_nxt;
    logic [ADDR_W-1:0]                r_addr;
    logic [RD_LATENCY-1:0]            r_pv;
    logic [RD_LATENCY*ADDR_W-1:0]     r_pa;
    logic [RD_LATENCY:0]              w_pv_chain;
    logic [(RD_LATENCY+1)*ADDR_W-1:0] w_pa_chain;
    logic                             w_in_read;
    logic                             w_accept;
    logic                             w_tail_v;
    logic [ADDR_W-1:0]                w_tail_addr;
    logic [DATA_W-1:0]                w_exp;
    logic                             w_mismatch;
    logic [ERR_W-1:0]                 r_err_cnt;
    logic                             r_pass;

    assign w_in_read = (r_state == S_READ);
    assign w_accept  = (r_state == S_IDLE) && start;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_READ;
            S_READ:  if (r_addr == C_LAST_ADDR) w_state_nxt = S_DRAIN;
            S_DRAIN: if (r_pv == '0) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_addr <= '0;
        end else if (w_in_read) begin
            r_addr <= r_addr + 1'b1;
        end else begin
            r_addr <= '0;
        end
    end

    // Chain position 0 is the read issued this cycle; the top position is the
    // entry whose data is on ram_doutb right now.
    assign w_pv_chain  = {r_pv, w_in_read};
    assign w_pa_chain  = {r_pa, r_addr};
    assign w_tail_v    = w_pv_chain[RD_LATENCY];
    assign w_tail_addr = w_pa_chain[(RD_LATENCY+1)*ADDR_W-1 -: ADDR_W];
    assign w_exp       = C_SEED + DATA_W'(w_tail_addr);
    assign w_mismatch  = w_tail_v && (ram_doutb != w_exp);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pv <= '0;
            r_pa <= '0;
        end else begin
            r_pv <= w_pv_chain[RD_LATENCY-1:0];
            r_pa <= w_pa_chain[RD_LATENCY*ADDR_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_err_cnt <= '0;
            r_pass    <= 1'b0;
        end else if (w_accept) begin
            r_err_cnt <= '0;
            r_pass    <= 1'b0;
        end else begin
            if (w_mismatch && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
            // Registered on entry to DONE so pass is valid alongside done.
            if ((r_state == S_DRAIN) && (w_state_nxt == S_DONE)) begin
                r_pass <= (r_err_cnt == '0);
            end
        end
    end

`ifdef RBC_FIRST_ERR_CAPTURE_EN
    logic [ADDR_W-1:0] r_fe_addr;
    logic [DATA_W-1:0] r_fe_data;

    // A zero count means no mismatch has been seen yet in this sweep.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_fe_addr <= '0;
            r_fe_data <= '0;
        end else if (w_accept) begin
            r_fe_addr <= '0;
            r_fe_data <= '0;
        end else if (w_mismatch && (r_err_cnt == '0)) begin
            r_fe_addr <= w_tail_addr;
            r_fe_data <= ram_doutb;
        end
    end

    assign first_err_addr = r_fe_addr;
    assign first_err_data = r_fe_data;
`else
    assign first_err_addr = '0;
    assign first_err_data = '0;
`endif

    assign busy      = (r_state == S_READ) || (r_state == S_DRAIN);
    assign done      = (r_state == S_DONE);
    assign pass      = r_pass;
    assign err_cnt   = r_err_cnt;
    assign ram_enb   = w_in_read;
    assign ram_addrb = w_in_read ? r_addr : '0;

endmodule

`default_nettype wire

// File: tb/tb_ram_readback_checker.sv
//==============================================================================
// tb_ram_readback_checker: directed self-checking bench for ram_readback_checker.
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_ram_readback_checker;

    logic        clk  = 1'b0;
    logic        rstn = 1'b0;
    logic        st0  = 1'b0;
    logic        st1  = 1'b0;

    logic        busy0, done0, pass0, enb0;
    logic [15:0] err0;
    logic [19:0] fea0, addr0;
    logic [15:0] fed0, dout0;

    logic        busy1, done1, pass1, enb1;
    logic [3:0]  err1;
    logic [19:0] fea1, addr1;
    logic [15:0] fed1, dout1, rd1a, rd1b;

    logic [15:0] mem0 [0:2047];
    logic [15:0] mem1 [0:2047];

    int checks = 0;
    int errors = 0;
    int done_at, ndone, nreads, nbad, nbusy;

    always #5 clk = ~clk;

    ram_readback_checker u_dut0 (
        .clk(clk), .rstn(rstn), .start(st0), .busy(busy0), .done(done0),
        .pass(pass0), .err_cnt(err0), .first_err_addr(fea0), .first_err_data(fed0),
        .ram_enb(enb0), .ram_addrb(addr0), .ram_doutb(dout0)
    );

    ram_readback_checker #(
        .RAM_SIZE(2048), .ADDR_W(20), .DATA_W(16), .RD_LATENCY(3),
        .SEED(65535), .ERR_W(4)
    ) u_dut1 (
        .clk(clk), .rstn(rstn), .start(st1), .busy(busy1), .done(done1),
        .pass(pass1), .err_cnt(err1), .first_err_addr(fea1), .first_err_data(fed1),
        .ram_enb(enb1), .ram_addrb(addr1), .ram_doutb(dout1)
    );

    always_ff @(posedge clk) begin
        if (enb0) dout0 <= mem0[addr0[10:0]];
    end

    always_ff @(posedge clk) begin
        if (enb1) rd1a <= mem1[addr1[10:0]];
        rd1b  <= rd1a;
        dout1 <= rd1b;
    end

    // restart_at >= 0: pulse start while that address is issued; -2: pulse start in the done cycle.
    task automatic run_sweep(input int sel, input int restart_at, input int abort_at);
        int          expa;
        logic        e, d, b;
        logic [19:0] a;
        expa = 0; done_at = -1; ndone = 0; nreads = 0; nbad = 0; nbusy = 0;
        @(negedge clk);
        if (sel == 0) st0 = 1'b1; else st1 = 1'b1;
        for (int c = 1; c <= 2100; c++) begin
            @(negedge clk);
            st0 = 1'b0; st1 = 1'b0;
            e = (sel == 0) ? enb0  : enb1;
            a = (sel == 0) ? addr0 : addr1;
            d = (sel == 0) ? done0 : done1;
            b = (sel == 0) ? busy0 : busy1;
            if (e) begin
                if (int'(a) != expa) nbad++;
                expa++;
                nreads++;
            end
            if (b) nbusy++;
            if (d) begin
                ndone++;
                if (done_at < 0) done_at = c;
                if (restart_at == -2) begin
                    if (sel == 0) st0 = 1'b1; else st1 = 1'b1;
                end
            end
            if (restart_at >= 0 && e && int'(a) == restart_at) begin
                if (sel == 0) st0 = 1'b1; else st1 = 1'b1;
            end
            if (abort_at >= 0 && e && int'(a) == abort_at) begin
                rstn = 1'b0;
                return;
            end
        end
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy0); end
        checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done0); end
        checks++; if (pass0 !== 1'b0) begin errors++; $display("FAIL reset_pass: got %b expected 0", pass0); end
        checks++; if (err0 !== 16'd0) begin errors++; $display("FAIL reset_err_cnt: got %0d expected 0", err0); end
        checks++; if ({enb0, addr0} !== 21'd0) begin errors++; $display("FAIL reset_ram_port: got enb=%b addr=%0d expected 0/0", enb0, addr0); end
        checks++; if ({fea0, fed0} !== 36'd0) begin errors++; $display("FAIL reset_first_err: got %0h/%0h expected 0/0", fea0, fed0); end
        checks++; if ({busy1, done1, pass1, err1} !== 7'd0) begin errors++; $display("FAIL reset_dut1: got %b expected 0", {busy1, done1, pass1, err1}); end
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_clean_sweep;
        run_sweep(0, -1, -1);
        checks++; if (done_at != 2051) begin errors++; $display("FAIL clean_latency: got %0d expected 2051", done_at); end
        checks++; if (ndone != 1) begin errors++; $display("FAIL clean_done_count: got %0d expected 1", ndone); end
        checks++; if (nreads != 2048 || nbad != 0) begin errors++; $display("FAIL clean_addr_seq: got reads=%0d bad=%0d expected 2048/0", nreads, nbad); end
        checks++; if (nbusy != 2050) begin errors++; $display("FAIL clean_busy_cycles: got %0d expected 2050", nbusy); end
        checks++; if (pass0 !== 1'b1) begin errors++; $display("FAIL clean_pass: got %b expected 1", pass0); end
        checks++; if (err0 !== 16'd0) begin errors++; $display("FAIL clean_err_cnt: got %0d expected 0", err0); end
        checks++; if ({fea0, fed0} !== 36'd0) begin errors++; $display("FAIL clean_first_err: got %0h/%0h expected 0/0", fea0, fed0); end
    endtask

    task automatic test_corrupt;
        mem0[100] = 16'hBEEF;
        run_sweep(0, -1, -1);
        checks++; if (err0 !== 16'd1) begin errors++; $display("FAIL corrupt_err_cnt: got %0d expected 1", err0); end
        checks++; if (pass0 !== 1'b0) begin errors++; $display("FAIL corrupt_pass: got %b expected 0", pass0); end
`ifdef RBC_FIRST_ERR_CAPTURE_EN
        checks++; if (fea0 !== 20'd100) begin errors++; $display("FAIL corrupt_first_addr: got %0d expected 100", fea0); end
        checks++; if (fed0 !== 16'hBEEF) begin errors++; $display("FAIL corrupt_first_data: got %0h expected beef", fed0); end
`else
        checks++; if ({fea0, fed0} !== 36'd0) begin errors++; $display("FAIL corrupt_first_err: got %0h/%0h expected 0/0", fea0, fed0); end
`endif
        mem0[100] = 16'd101;
    endtask

    task automatic test_back_to_back;
        run_sweep(0, 500, -1);
        checks++; if (done_at != 2051 || ndone != 1) begin errors++; $display("FAIL midstart_done: got at=%0d n=%0d expected 2051/1", done_at, ndone); end
        checks++; if (nreads != 2048 || nbad != 0) begin errors++; $display("FAIL midstart_addr_seq: got reads=%0d bad=%0d expected 2048/0", nreads, nbad); end
        checks++; if (err0 !== 16'd0 || pass0 !== 1'b1) begin errors++; $display("FAIL midstart_result: got err=%0d pass=%b expected 0/1", err0, pass0); end
        run_sweep(0, -2, -1);
        checks++; if (nreads != 2048 || ndone != 1) begin errors++; $display("FAIL donestart_ignored: got reads=%0d dones=%0d expected 2048/1", nreads, ndone); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL donestart_busy: got %b expected 0", busy0); end
    endtask

    task automatic test_abort;
        int late_done;
        mem0[5] = 16'd0;
        run_sweep(0, -1, 1000);
        #1;
        checks++; if (err0 !== 16'd0) begin errors++; $display("FAIL abort_err_cnt: got %0d expected 0", err0); end
        checks++; if ({busy0, done0, pass0, enb0} !== 4'd0) begin errors++; $display("FAIL abort_flags: got %b expected 0000", {busy0, done0, pass0, enb0}); end
        checks++; if (addr0 !== 20'd0) begin errors++; $display("FAIL abort_addr: got %0d expected 0", addr0); end
        mem0[5] = 16'd6;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        late_done = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (done0 || busy0) late_done++;
        end
        checks++; if (late_done != 0) begin errors++; $display("FAIL abort_no_done: got %0d active cycles expected 0", late_done); end
        run_sweep(0, -1, -1);
        checks++; if (done_at != 2051 || nreads != 2048 || nbad != 0) begin errors++; $display("FAIL abort_resweep: got at=%0d reads=%0d bad=%0d expected 2051/2048/0", done_at, nreads, nbad); end
        checks++; if (pass0 !== 1'b1 || err0 !== 16'd0) begin errors++; $display("FAIL abort_resweep_result: got pass=%b err=%0d expected 1/0", pass0, err0); end
    endtask

    task automatic test_saturate;
        for (int i = 0; i < 2048; i++) mem1[i] = 16'd0;
        run_sweep(1, -1, -1);
        checks++; if (err1 !== 4'd15) begin errors++; $display("FAIL sat_all_zero: got %0d expected 15", err1); end
        checks++; if (pass1 !== 1'b0) begin errors++; $display("FAIL sat_pass: got %b expected 0", pass1); end
        // 2041 mismatches: a wrapping counter would read 9, not 15.
        for (int i = 0; i < 7; i++) mem1[i] = 16'(65535 + i);
        run_sweep(1, -1, -1);
        checks++; if (err1 !== 4'd15) begin errors++; $display("FAIL sat_no_wrap: got %0d expected 15", err1); end
    endtask

    task automatic test_wrap_latency3;
        for (int i = 0; i < 2048; i++) mem1[i] = 16'(65535 + i);
        run_sweep(1, -1, -1);
        checks++; if (done_at != 2053 || ndone != 1) begin errors++; $display("FAIL lat3_done: got at=%0d n=%0d expected 2053/1", done_at, ndone); end
        checks++; if (nreads != 2048 || nbad != 0) begin errors++; $display("FAIL lat3_addr_seq: got reads=%0d bad=%0d expected 2048/0", nreads, nbad); end
        checks++; if (pass1 !== 1'b1 || err1 !== 4'd0) begin errors++; $display("FAIL lat3_wrap_result: got pass=%b err=%0d expected 1/0", pass1, err1); end
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) begin
            mem0[i] = 16'(i + 1);
            mem1[i] = 16'(65535 + i);
        end
        test_reset();
        test_clean_sweep();
        test_corrupt();
        test_back_to_back();
        test_abort();
        test_saturate();
        test_wrap_latency3();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ram_readback_checker.md
Name: ram_readback_checker

Overview:
- Read-side companion to the periodic RAM write/read exerciser. It owns port B of the simple dual-port block RAM and runs a full readback sweep when triggered.
- Each returned word is compared against the known write pattern (SEED + address). The block counts mismatches and reports a pass/fail result with a done pulse.
- Sits beside the port-A writer. Its status outputs are intended for debug probes and LEDs.

Parameters:
- RAM_SIZE, 2048, number of words swept; addresses 0..RAM_SIZE-1.
- ADDR_W, 20, width of ram_addrb.
- DATA_W, 16, width of RAM data and of the expected pattern.
- RD_LATENCY, 1, cycles from ram_enb/ram_addrb to valid ram_doutb; legal values 1..3.
- SEED, 1, expected data at address 0.
- ERR_W, 16, width of err_cnt.

Ports:
- clk  in  1  system clock.
- rstn  in  1  reset, asynchronous, active-low.
- start  in  1  single-cycle request to begin a sweep.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the sweep completes.
- pass  out  1  last sweep had zero mismatches; held until next accepted start.
- err_cnt  out  ERR_W  mismatch count of the current/last sweep.
- first_err_addr  out  ADDR_W  address of the first mismatch (feature-dependent, see below).
- first_err_data  out  DATA_W  data read at the first mismatch (feature-dependent).
- ram_enb  out  1  RAM port-B enable.
- ram_addrb  out  ADDR_W  RAM port-B address.
- ram_doutb  in  DATA_W  RAM port-B read data.

Behaviour:
- Reset values: all outputs 0. The FSM enters IDLE and the pipeline valid bits clear. Assertion of rstn mid-sweep aborts immediately; no done pulse is issued.
- States and transitions:
  - IDLE -> READ on start.
  - READ -> DRAIN after issuing address RAM_SIZE-1.
  - DRAIN -> DONE when the compare pipeline is empty.
  - DONE -> IDLE after one cycle.
- Accepting start (IDLE):
  - err_cnt and pass clear and busy rises on the next edge.
  - start in any other state is ignored, with no effect on the sweep.
- READ:
  - ram_enb = 1 and ram_addrb = 0,1,2,... with one address per cycle, no gaps.
  - RAM_SIZE cycles in total.
- Outside READ: ram_enb = 0 and ram_addrb = 0.
- Compare pipeline:
  - A RD_LATENCY-deep shift register carries (valid, addr) alongside each issued read.
  - When a valid entry emerges, ram_doutb is compared with expected = (SEED + addr) truncated to DATA_W, which wraps modulo 2^DATA_W.
  - Mismatch increments err_cnt, saturating at 2^ERR_W-1 with no wrap.
- DONE:
  - done = 1 for exactly one cycle.
  - pass = (err_cnt == 0) is registered in the same cycle.
  - busy falls in the same cycle that done is asserted.
- Total latency from start to done = 1 + RAM_SIZE + RD_LATENCY + 1 cycles.
- A start arriving in the same cycle as done is ignored. A new sweep needs start while in IDLE.
- err_cnt, pass and first_err_* are stable from done until the next accepted start.

Optional Feature:
- Macro RBC_FIRST_ERR_CAPTURE_EN.
- Defined:
  - On the first mismatch of a sweep, first_err_addr and first_err_data latch the failing address and read data.
  - Later mismatches do not overwrite them.
  - Both clear on accepted start.
  - If no mismatch occurs, both stay 0.
- Undefined: first_err_addr and first_err_data are tied to 0 and no capture registers exist.

Test Plan:
- RAM preloaded with 1..2048 (SEED=1), pulse start -> ram_addrb 0..2047 contiguous; done after 2051 cycles (RD_LATENCY=1); pass=1; err_cnt=0.
- Same preload with word 100 corrupted to 0xBEEF -> err_cnt=1, pass=0. With macro: first_err_addr=100, first_err_data=0xBEEF.
- All RAM words 0, ERR_W=4 -> err_cnt saturates at 15 with no wrap; pass=0.
- Start pulsed again at address 500 mid-sweep -> ignored; sweep still ends at 2047 with exactly one done pulse.
- rstn asserted at address 1000 -> all outputs 0 immediately; no done; a later start performs a clean full sweep.
- RD_LATENCY=3, SEED=0xFFFF, RAM holds 0xFFFF,0x0000,0x0001,... -> pass=1 (pattern wraps modulo 2^16); done 2053 cycles after start.
